// File: rtl/div_arbiter_if.sv
//==============================================================================
// Module  : div_arbiter_if
// Purpose : Requester, response and divider-side signals of div_arbiter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface div_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_signctl;
    logic             req0_rem;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_signctl;
    logic             req1_rem;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_signctl;
    logic             div_remainder_out;
    logic             div_rst;
    logic [WIDTH-1:0] div_dout;
    logic             div_drdy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_signctl, req0_rem,
        input  req1_valid, req1_a, req1_b, req1_signctl, req1_rem,
        input  div_dout, div_drdy,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        output div_a, div_b, div_signctl, div_remainder_out, div_rst
    );

    // Requester / divider environment side
    modport master (
        output req0_valid, req0_a, req0_b, req0_signctl, req0_rem,
        output req1_valid, req1_a, req1_b, req1_signctl, req1_rem,
        output div_dout, div_drdy,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        input  div_a, div_b, div_signctl, div_remainder_out, div_rst
    );
endinterface

`default_nettype wire

// File: rtl/div_arbiter.sv
//==============================================================================
// Module  : div_arbiter
// Purpose : Round-robin two-port sequencer for the shared iterative divider.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module div_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    div_arbiter_if.slave bus
);

    localparam int                c_TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_prio;
    logic               r_owner;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sign;
    logic               r_rem;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_err;

    logic               w_any;
    logic               w_grant;
    logic               w_timeout;

    assign w_any     = bus.req0_valid | bus.req1_valid;
    // Contention resolves to r_prio; otherwise req1_valid alone names the winner
    assign w_grant   = (bus.req0_valid & bus.req1_valid) ? r_prio : bus.req1_valid;
    assign w_timeout = (r_timer == c_TMR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_CLEAR;
            S_CLEAR: w_next = S_WAIT;
            S_WAIT:  if (bus.div_drdy || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= 1'b0;
            r_owner    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_rem      <= 1'b0;
            r_timer    <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_grant;
                        r_a     <= w_grant ? bus.req1_a       : bus.req0_a;
                        r_b     <= w_grant ? bus.req1_b       : bus.req0_b;
                        r_sign  <= w_grant ? bus.req1_signctl : bus.req0_signctl;
                        r_rem   <= w_grant ? bus.req1_rem     : bus.req0_rem;
                    end
                end
                S_CLEAR: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.div_drdy) begin
                        r_rsp_data <= bus.div_dout;
                        r_rsp_err  <= 1'b0;
                        r_rsp_id   <= r_owner;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_rsp_id   <= r_owner;
                    end
                end
                S_RESP: begin
                    r_prio <= ~r_owner;
                end
                default: ;
            endcase
        end
    end

    // Ready is gated by rst_n so a held request is never acknowledged during reset
    assign bus.req0_ready        = rst_n & (r_state == S_IDLE) & w_any & ~w_grant;
    assign bus.req1_ready        = rst_n & (r_state == S_IDLE) & w_any &  w_grant;

    assign bus.rsp_valid         = (r_state == S_RESP);
    assign bus.rsp_id            = r_rsp_id;
    assign bus.rsp_data          = r_rsp_data;
    assign bus.rsp_err           = r_rsp_err;

    assign bus.div_a             = r_a;
    assign bus.div_b             = r_b;
    assign bus.div_signctl       = r_sign;
    assign bus.div_remainder_out = r_rem;
    assign bus.div_rst           = (r_state != S_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter; the bench plays both requesters and the divider.
`default_nettype none

module tb_div_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    div_arbiter_if #(.WIDTH(32)) bus ();

    div_arbiter #(.WIDTH(32), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from its handshake cycle (cycle 0) until rsp_valid.
    // drdy pulses in cycles d1/d2 counted from the handshake; returns latency,
    // ready-high cycles seen while busy, and cycles with wrong div_* values.
    task automatic wait_rsp(input int d1, input int d2, input logic [31:0] dout,
                            input logic drop, input logic [31:0] ea, input logic [31:0] eb,
                            input logic es, input logic er,
                            output int lat, output int nrdy, output int nop);
        lat  = -1;
        nrdy = 0;
        nop  = 0;
        for (int c = 1; c <= 200; c++) begin
            tick;
            if (drop) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            bus.div_drdy = (c == d1) || (c == d2);
            bus.div_dout = dout;
            #1;
            if (bus.req0_ready || bus.req1_ready) nrdy++;
            if (bus.div_a !== ea || bus.div_b !== eb || bus.div_signctl !== es ||
                bus.div_remainder_out !== er ||
                bus.div_rst !== ((c == 1) || (bus.rsp_valid === 1'b1)))
                nop++;
            if (bus.rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        bus.div_drdy = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick;
        tick;
        total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
        total++; if (bus.div_rst !== 1'b1) begin bad++; $display("FAIL reset_div_rst: got %b want 1", bus.div_rst); end
        total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== 3'b000) begin bad++; $display("FAIL reset_rsp_flags: got %b want 000", {bus.rsp_valid, bus.rsp_id, bus.rsp_err}); end
        total++; if (bus.rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        total++; if ({bus.div_a, bus.div_b, bus.div_signctl, bus.div_remainder_out} !== 66'h0) begin bad++; $display("FAIL reset_div_ops: got %h want 0", {bus.div_a, bus.div_b, bus.div_signctl, bus.div_remainder_out}); end

        // Abort mid-WAIT: req0 stays valid so the ready gating is exercised
        bus.req1_valid = 1'b0;
        bus.req0_a = 32'd5; bus.req0_b = 32'd1; bus.req0_signctl = 1'b0; bus.req0_rem = 1'b0;
        rst_n = 1'b1;
        #1;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        total++; if (bus.div_rst !== 1'b1) begin bad++; $display("FAIL abort_div_rst: got %b want 1", bus.div_rst); end
        total++; if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b000) begin bad++; $display("FAIL abort_valid_ready: got %b want 000", {bus.rsp_valid, bus.req1_ready, bus.req0_ready}); end
        bus.req0_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            bus.div_drdy = (i < 5);
            tick;
            if (bus.rsp_valid === 1'b1) n++;
        end
        bus.div_drdy = 1'b0;
        total++; if (n !== 0) begin bad++; $display("FAIL abort_no_rsp: got %0d responses want 0", n); end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin bad++; $display("FAIL abort_prio: got %b want 01", {bus.req1_ready, bus.req0_ready}); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_single;
        int lat, nr, no;
        bus.req0_a = 32'd100; bus.req0_b = 32'd7; bus.req0_signctl = 1'b0; bus.req0_rem = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", bus.req0_ready); end
        wait_rsp(11, 0, 32'd14, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0, lat, nr, no);
        total++; if (lat !== 12) begin bad++; $display("FAIL single_latency: got %0d want 12", lat); end
        total++; if ({bus.rsp_id, bus.rsp_err} !== 2'b00) begin bad++; $display("FAIL single_id_err: got %b want 00", {bus.rsp_id, bus.rsp_err}); end
        total++; if (bus.rsp_data !== 32'd14) begin bad++; $display("FAIL single_data: got %h want 0000000e", bus.rsp_data); end
        total++; if (nr !== 0 || no !== 0) begin bad++; $display("FAIL single_busy: got ready=%0d opbad=%0d want 0 0", nr, no); end
        tick;
        total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd14) begin bad++; $display("FAIL single_strobe_hold: got valid=%b data=%h want 0 0000000e", bus.rsp_valid, bus.rsp_data); end
    endtask

    task automatic test_arbitration;
        int lat, nr, no;
        logic e;
        rst_n = 1'b0;
        bus.req0_a = 32'd10; bus.req0_b = 32'd2; bus.req0_signctl = 1'b0; bus.req0_rem = 1'b0;
        bus.req1_a = 32'd20; bus.req1_b = 32'd3; bus.req1_signctl = 1'b0; bus.req1_rem = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick;
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            e = (g % 2 == 1);
            total++; if ({bus.req1_ready, bus.req0_ready} !== (e ? 2'b10 : 2'b01)) begin bad++; $display("FAIL arb_grant%0d: got %b want %b", g, {bus.req1_ready, bus.req0_ready}, (e ? 2'b10 : 2'b01)); end
            wait_rsp(3, 0, 32'(g), 1'b0, e ? 32'd20 : 32'd10, e ? 32'd3 : 32'd2, 1'b0, 1'b0, lat, nr, no);
            total++; if (lat !== 4 || nr !== 0 || no !== 0) begin bad++; $display("FAIL arb_op%0d: got lat=%0d ready=%0d opbad=%0d want 4 0 0", g, lat, nr, no); end
            total++; if (bus.rsp_id !== e || bus.rsp_data !== 32'(g)) begin bad++; $display("FAIL arb_rsp%0d: got id=%b data=%h want %b %h", g, bus.rsp_id, bus.rsp_data, e, 32'(g)); end
            tick;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_signed_rem;
        int lat, nr, no;
        bus.req1_a = 32'hFFFF_FFF9; bus.req1_b = 32'd2; bus.req1_signctl = 1'b1; bus.req1_rem = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin bad++; $display("FAIL srem_ready: got %b want 10", {bus.req1_ready, bus.req0_ready}); end
        wait_rsp(5, 0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, lat, nr, no);
        total++; if (lat !== 6 || no !== 0) begin bad++; $display("FAIL srem_passthru: got lat=%0d opbad=%0d want 6 0", lat, no); end
        total++; if (bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'hFFFF_FFFF || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL srem_rsp: got id=%b data=%h err=%b want 1 ffffffff 0", bus.rsp_id, bus.rsp_data, bus.rsp_err); end
        tick;
    endtask

    task automatic test_timeout;
        int lat, nr, no;
        bus.req0_a = 32'd1; bus.req0_b = 32'd0; bus.req0_signctl = 1'b0; bus.req0_rem = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        wait_rsp(0, 0, 32'hDEAD_BEEF, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, lat, nr, no);
        total++; if (lat !== 66) begin bad++; $display("FAIL timeout_latency: got %0d want 66", lat); end
        total++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 1'b0) begin bad++; $display("FAIL timeout_rsp: got err=%b data=%h id=%b want 1 00000000 0", bus.rsp_err, bus.rsp_data, bus.rsp_id); end
        tick;
        bus.req0_a = 32'd9; bus.req0_b = 32'd3;
        bus.req0_valid = 1'b1;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL after_timeout_ready: got %b want 1", bus.req0_ready); end
        wait_rsp(2, 0, 32'd3, 1'b1, 32'd9, 32'd3, 1'b0, 1'b0, lat, nr, no);
        total++; if (lat !== 3 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'd3) begin bad++; $display("FAIL after_timeout_op: got lat=%0d err=%b data=%h want 3 0 00000003", lat, bus.rsp_err, bus.rsp_data); end
        tick;
    endtask

    task automatic test_late_drdy;
        int lat, nr, no, n;
        bus.req1_a = 32'd50; bus.req1_b = 32'd5; bus.req1_signctl = 1'b0; bus.req1_rem = 1'b0;
        bus.req1_valid = 1'b1;
        #1;
        wait_rsp(1, 5, 32'd10, 1'b1, 32'd50, 32'd5, 1'b0, 1'b0, lat, nr, no);
        total++; if (lat !== 6) begin bad++; $display("FAIL late_latency: got %0d want 6", lat); end
        total++; if (bus.rsp_data !== 32'd10 || bus.rsp_id !== 1'b1) begin bad++; $display("FAIL late_rsp: got data=%h id=%b want 0000000a 1", bus.rsp_data, bus.rsp_id); end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            bus.div_drdy = 1'b1;
            tick;
            if (bus.rsp_valid === 1'b1) n++;
        end
        bus.div_drdy = 1'b0;
        total++; if (n !== 0) begin bad++; $display("FAIL late_single_rsp: got %0d extra responses want 0", n); end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_signctl = 1'b0; bus.req0_rem = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_signctl = 1'b0; bus.req1_rem = 1'b0;
        bus.div_dout   = '0;
        bus.div_drdy   = 1'b0;
        test_reset;
        test_single;
        test_arbitration;
        test_signed_rem;
        test_timeout;
        test_late_drdy;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_arbiter.md
# div_arbiter

Sequencer and two-port arbiter for the shared iterative divider `div`. It accepts divide requests from two requesters over valid/ready handshakes and grants them round-robin. It drives the divider's operand, mode and clear inputs, waits for `drdy`, and returns the result on a shared response bus tagged with the requester id. A watchdog aborts operations that never complete.

## Interface
- `WIDTH`, 32, operand/result width (matches `div`)
- `TIMEOUT`, 64, max WAIT cycles before abort (≥2)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_a`, `req0_b`  in  WIDTH  dividend, divisor
- `req0_signctl`  in  1  1 = signed divide
- `req0_rem`  in  1  1 = return remainder, 0 = quotient
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_signctl`, `req1_rem`: same as port 0
- `rsp_valid`  out  1  one-cycle response strobe
- `rsp_id`  out  1  requester that owns the response
- `rsp_data`  out  WIDTH  quotient/remainder (0 on error)
- `rsp_err`  out  1  1 = timeout abort
- `div_a`, `div_b`  out  WIDTH  divider operands
- `div_signctl`, `div_remainder_out`  out  1  divider mode
- `div_rst`  out  1  active-high clear/start to `div`
- `div_dout`  in  WIDTH  divider result
- `div_drdy`  in  1  divider result valid

## Operation
- Reset (`rst_n`=0, async):
  - State is IDLE; `prio`=0; timer=0.
  - Operand/mode regs are 0; `div_a`/`div_b`/mode outputs are 0.
  - `rsp_valid`/`rsp_id`/`rsp_data`/`rsp_err` are 0; `div_rst`=1.
  - Both `reqN_ready`=0.
- FSM:
  - **IDLE:**
    - `div_rst`=1.
    - Grant when any `reqN_valid`. If both are valid, grant requester `prio`; otherwise grant the one that is valid.
    - `reqN_ready` is combinational: 1 only in IDLE for the granted requester.
    - On handshake, latch a/b/signctl/rem and the owner id, then go to CLEAR.
  - **CLEAR:** one cycle. `div_rst`=1 with latched operands on `div_*`. Go to WAIT with timer=0.
  - **WAIT:**
    - `div_rst`=0; timer increments each cycle.
    - If `div_drdy`=1, capture `div_dout` into `rsp_data`, set `rsp_err`=0, go to RESP.
    - Otherwise, if timer==TIMEOUT-1, set `rsp_data`=0, `rsp_err`=1, go to RESP.
  - **RESP:**
    - `rsp_valid`=1 for exactly one cycle; `rsp_id`=owner; `div_rst`=1.
    - `prio` ← ~owner.
    - Go to IDLE.
- `div_a`/`div_b`/mode are driven from latched regs and stay stable from CLEAR through RESP.
- Requester inputs are ignored outside the IDLE handshake cycle.
- `rsp_data`/`rsp_id`/`rsp_err` hold their values until the next RESP. There is no response backpressure; requesters must sample on `rsp_valid`.
- Divide-by-zero and signed semantics are defined entirely by `div`. The arbiter passes them through unchanged.
- At most one operation is in flight.

## Timing
- Handshake in cycle 0 → CLEAR in cycle 1 → WAIT from cycle 2.
- `div_drdy` seen in WAIT cycle k → `rsp_valid` in cycle k+1.
- Minimum handshake-to-response latency is 3 cycles.
- Next grant is possible in the cycle after RESP; back-to-back throughput is one operation per (divider latency + 3) cycles.
- Timeout: with `drdy` never high, `rsp_valid` (err) occurs exactly TIMEOUT+2 cycles after the handshake.
- `drdy` in CLEAR or IDLE is ignored.
- `reqN_valid` while busy: `ready` stays 0 and the request is held, not dropped.
- `rst_n` low mid-operation: immediate abort with no response; `div_rst`=1 and `prio`=0 after release.

## Test plan
- **Reset:** drive `rst_n`=0 mid-WAIT → immediately `div_rst`=1, `rsp_valid`=0, `req0_ready`=`req1_ready`=0, no response after release.
- **Single op:** req0 a=100, b=7, signctl=0, rem=0; div model asserts `drdy` with dout=14 on the 10th WAIT cycle → single-cycle `rsp_valid`, `rsp_id`=0, `rsp_data`=14, `rsp_err`=0, 12 cycles after the handshake.
- **Arbitration:** both requesters hold valid continuously from reset → grants alternate 0,1,0,1. Each `ready` is high for exactly one cycle per grant, and `rsp_id` matches.
- **Signed remainder passthrough:** req1 a=32'hFFFFFFF9, b=2, signctl=1, rem=1 → `div_a`/`div_b`/`div_signctl`/`div_remainder_out` equal the request during CLEAR..RESP; model dout=32'hFFFFFFFF returned with `rsp_id`=1.
- **Timeout:** TIMEOUT=64, `drdy` held 0 → `rsp_valid` with `rsp_err`=1 and `rsp_data`=0, 66 cycles after the handshake. The next request then completes normally.
- **Late drdy:** `drdy` pulse during CLEAR only → ignored; the later pulse in WAIT produces exactly one response.
